eth_rx_frame_fifo: RTL and testbench

//  Store-and-forward RX frame buffer placed directly after the MAC-address filter stage.

---
 rtl/eth_rx_frame_fifo_if.sv | 15 +
 rtl/eth_rx_frame_fifo.sv | 82 ++++++++
 tb/tb_eth_rx_frame_fifo.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_frame_fifo_if.sv
// eth_rx_frame_fifo_if: RX byte stream in (no backpressure) and backpressured AXIS byte stream out
interface eth_rx_frame_fifo_if;
  logic [7:0] in_tdata;
  logic       in_tvalid;
  logic       in_tlast;
  logic       in_tuser;
  logic [7:0] out_tdata;
  logic       out_tvalid;
  logic       out_tready;
  logic       out_tlast;
  modport master (output in_tdata, in_tvalid, in_tlast, in_tuser, out_tready,
                  input out_tdata, out_tvalid, out_tlast);
  modport slave (input in_tdata, in_tvalid, in_tlast, in_tuser, out_tready,
                 output out_tdata, out_tvalid, out_tlast);
endinterface

// File: rtl/eth_rx_frame_fifo.sv
// eth_rx_frame_fifo: store-and-forward RX frame buffer that only releases good, full-length frames
module eth_rx_frame_fifo #(
  parameter int DEPTH   = 2048,
  parameter int MIN_LEN = 14,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  eth_rx_frame_fifo_if.slave bus,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic [CNT_W-1:0] bad_drop_cnt_o,
  output logic [CNT_W-1:0] ovf_drop_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [15:0] MIN = 16'(MIN_LEN);
  typedef enum logic [1:0] {SYNC, IDLE, RECV, DROP} state_t;
  state_t state, state_n;
  logic [8:0] mem [DEPTH];
  logic [8:0] ram_q;
  logic [AW:0] wr_ptr, commit_ptr, rd_ptr, occ;
  logic [15:0] len, len_n;
  logic full, accept, wen, good, bad, ovf, ovf_end, ram_v, move, issue;
  // occ never exceeds DEPTH, so its MSB alone flags a full buffer
  assign occ  = wr_ptr - rd_ptr;
  assign full = occ[AW];
  always_comb begin
    accept  = bus.in_tvalid && (state == IDLE || state == RECV);
    len_n   = (state == IDLE) ? 16'd1 : len + 16'(len != 16'hffff);
    wen     = accept && !full;
    good    = wen && bus.in_tlast && !bus.in_tuser && len_n >= MIN;
    bad     = wen && bus.in_tlast && !good;
    ovf     = accept && full;
    ovf_end = bus.in_tvalid && bus.in_tlast && (ovf || state == DROP);
    state_n = (state == SYNC) ? (bus.in_tvalid ? SYNC : IDLE)
            : accept ? (bus.in_tlast ? IDLE : full ? DROP : RECV)
            : ovf_end ? IDLE : state;
    move    = ram_v && (!bus.out_tvalid || bus.out_tready);
    issue   = (rd_ptr != commit_ptr) && (!ram_v || move);
  end
  always_ff @(posedge clk_i) begin
    if (wen) mem[wr_ptr[AW-1:0]] <= {bus.in_tlast, bus.in_tdata};
    if (issue) ram_q <= mem[rd_ptr[AW-1:0]];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= SYNC;
      wr_ptr         <= '0;
      commit_ptr     <= '0;
      len            <= '0;
      frame_cnt_o    <= '0;
      bad_drop_cnt_o <= '0;
      ovf_drop_cnt_o <= '0;
    end else begin
      state <= state_n;
      if (accept) len <= len_n;
      if (good) begin
        wr_ptr     <= wr_ptr + ONE;
        commit_ptr <= wr_ptr + ONE;
      end else if (bad || ovf) wr_ptr <= commit_ptr;
      else if (wen) wr_ptr <= wr_ptr + ONE;
      frame_cnt_o    <= frame_cnt_o + CNT_W'(good && !(&frame_cnt_o));
      bad_drop_cnt_o <= bad_drop_cnt_o + CNT_W'(bad && !(&bad_drop_cnt_o));
      ovf_drop_cnt_o <= ovf_drop_cnt_o + CNT_W'(ovf_end && !(&ovf_drop_cnt_o));
    end
  end
  // two-stage prefetch: RAM read register, then the AXIS output register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr         <= '0;
      ram_v          <= 1'b0;
      bus.out_tvalid <= 1'b0;
      bus.out_tlast  <= 1'b0;
      bus.out_tdata  <= '0;
    end else begin
      if (issue) rd_ptr <= rd_ptr + ONE;
      ram_v <= issue || (ram_v && !move);
      if (move) {bus.out_tlast, bus.out_tdata} <= ram_q;
      bus.out_tvalid <= move || (bus.out_tvalid && !bus.out_tready);
    end
  end
endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// tb_eth_rx_frame_fifo: directed checks of the RX frame FIFO with immediate assertions
module tb_eth_rx_frame_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] d = '0;
  logic v = 1'b0, l = 1'b0, u = 1'b0, sel = 1'b0;
  logic rdy_a = 1'b1, rdy_b = 1'b1, rmode = 1'b0, rnd = 1'b0;
  logic [15:0] fa, ba, oa, fb, bb, ob;
  logic [8:0] exp_a[$], got_a[$], exp_b[$], got_b[$];
  logic [8:0] prev = '0;
  logic hold = 1'b0;
  int n_chk = 0, n_fail = 0, stall_err = 0;
  eth_rx_frame_fifo_if bus_a();
  eth_rx_frame_fifo_if bus_b();
  assign bus_a.in_tdata = d;
  assign bus_a.in_tvalid = v & !sel;
  assign bus_a.in_tlast = l;
  assign bus_a.in_tuser = u;
  assign bus_a.out_tready = rmode ? rnd : rdy_a;
  assign bus_b.in_tdata = d;
  assign bus_b.in_tvalid = v & sel;
  assign bus_b.in_tlast = l;
  assign bus_b.in_tuser = u;
  assign bus_b.out_tready = rdy_b;
  eth_rx_frame_fifo dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a),
    .frame_cnt_o(fa), .bad_drop_cnt_o(ba), .ovf_drop_cnt_o(oa));
  eth_rx_frame_fifo #(.DEPTH(64)) dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b),
    .frame_cnt_o(fb), .bad_drop_cnt_o(bb), .ovf_drop_cnt_o(ob));
  always #4 clk = ~clk;
  always @(posedge clk) begin
    #1;
    rnd = 1'($urandom_range(0, 1));
  end
  always @(negedge clk) begin
    if (bus_a.out_tvalid && bus_a.out_tready) got_a.push_back({bus_a.out_tlast, bus_a.out_tdata});
    if (bus_b.out_tvalid && bus_b.out_tready) got_b.push_back({bus_b.out_tlast, bus_b.out_tdata});
    if (hold && !rst && (!bus_a.out_tvalid || {bus_a.out_tlast, bus_a.out_tdata} != prev)) stall_err++;
    hold = !rst && bus_a.out_tvalid && !bus_a.out_tready;
    prev = {bus_a.out_tlast, bus_a.out_tdata};
  end
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int n, input logic [7:0] base, input logic user, input logic keep, input logic gap);
    for (int i = 0; i < n; i++) begin
      d = base + 8'(i * 3) + 8'(i >> 8);
      v = 1'b1;
      l = (i == n - 1);
      u = user & l;
      if (keep) begin
        if (sel) exp_b.push_back({l, d});
        else exp_a.push_back({l, d});
      end
      step();
    end
    v = 1'b0;
    l = 1'b0;
    u = 1'b0;
    if (gap) step();
  endtask
  task automatic drain_a(input string tag);
    int t = 0;
    int bad = 0;
    while (got_a.size() < exp_a.size() && t < 20000) begin
      step();
      t++;
    end
    repeat (20) step();
    chk({tag, "_count"}, got_a.size(), exp_a.size());
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++)
      if (got_a[i] !== exp_a[i]) bad++;
    chk({tag, "_bytes"}, bad, 0);
    got_a.delete();
    exp_a.delete();
  endtask
  initial begin
    repeat (3) step();
    chk("rst_tvalid", bus_a.out_tvalid, 0);
    chk("rst_tlast", bus_a.out_tlast, 0);
    chk("rst_tdata", bus_a.out_tdata, 0);
    chk("rst_frame_cnt", fa, 0);
    chk("rst_bad_cnt", ba, 0);
    chk("rst_ovf_cnt", oa, 0);
    rst = 1'b0;
    step();
    // 64-byte good frame and first-byte latency
    send(64, 8'h10, 1'b0, 1'b1, 1'b0);
    chk("lat_edge0", bus_a.out_tvalid, 0);
    step();
    chk("lat_edge1", bus_a.out_tvalid, 0);
    step();
    chk("lat_edge2", bus_a.out_tvalid, 1);
    chk("lat_first_byte", bus_a.out_tdata, 8'h10);
    drain_a("t1");
    chk("t1_frame_cnt", fa, 1);
    // bad FCS frame followed by a good one
    send(64, 8'h40, 1'b1, 1'b0, 1'b1);
    send(60, 8'h80, 1'b0, 1'b1, 1'b1);
    drain_a("t2");
    chk("t2_frame_cnt", fa, 2);
    chk("t2_bad_cnt", ba, 1);
    // runts around MIN_LEN and a single-beat frame
    send(10, 8'h01, 1'b0, 1'b0, 1'b1);
    send(13, 8'h02, 1'b0, 1'b0, 1'b1);
    send(14, 8'hc0, 1'b0, 1'b1, 1'b1);
    send(1, 8'h03, 1'b0, 1'b0, 1'b1);
    drain_a("t3");
    chk("t3_frame_cnt", fa, 3);
    chk("t3_bad_cnt", ba, 4);
    chk("t3_ovf_cnt", oa, 0);
    // reset in the middle of a 100-byte frame
    for (int i = 0; i < 100; i++) begin
      d = 8'(i);
      v = 1'b1;
      l = (i == 99);
      rst = (i >= 20 && i < 22);
      step();
    end
    v = 1'b0;
    l = 1'b0;
    rst = 1'b0;
    step();
    chk("t5_frame_cnt_after_rst", fa, 0);
    chk("t5_bad_cnt_after_rst", ba, 0);
    send(64, 8'h55, 1'b0, 1'b1, 1'b1);
    drain_a("t5");
    chk("t5_frame_cnt", fa, 1);
    chk("t5_bad_cnt", ba, 0);
    // random backpressure, mixed good/bad frames, pointer wrap
    rmode = 1'b1;
    for (int f = 0; f < 24; f++) begin
      int t = 0;
      logic bf;
      bf = (f % 5 == 4);
      send($urandom_range(64, 600), 8'($urandom), bf, !bf, 1'b1);
      while (exp_a.size() - got_a.size() > 1024 && t < 20000) begin
        step();
        t++;
      end
    end
    drain_a("t6");
    rmode = 1'b0;
    chk("t6_frame_cnt", fa, 21);
    chk("t6_bad_cnt", ba, 4);
    chk("t6_ovf_cnt", oa, 0);
    chk("t6_stall_hold", stall_err, 0);
    // small buffer overflow with output stalled
    sel = 1'b1;
    rdy_b = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    send(40, 8'h20, 1'b0, 1'b1, 1'b1);
    send(40, 8'h60, 1'b0, 1'b0, 1'b1);
    repeat (5) step();
    chk("t4_frame_cnt", fb, 1);
    chk("t4_ovf_cnt", ob, 1);
    chk("t4_bad_cnt", bb, 0);
    chk("t4_stall_valid", bus_b.out_tvalid, 1);
    chk("t4_stall_data", bus_b.out_tdata, 8'h20);
    rdy_b = 1'b1;
    begin
      int t = 0;
      int bad = 0;
      while (got_b.size() < exp_b.size() && t < 2000) begin
        step();
        t++;
      end
      repeat (20) step();
      chk("t4_count", got_b.size(), 40);
      for (int i = 0; i < got_b.size() && i < exp_b.size(); i++)
        if (got_b[i] !== exp_b[i]) bad++;
      chk("t4_bytes", bad, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
